// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider: one quotient bit per cycle, signed or unsigned,
// with early divide-by-zero completion and cancellation.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic               annul_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    output logic               busy_o,
    output logic               ready_o,
    output logic [2*WIDTH-1:0] result_o,
    output logic               div_by_zero_o
);

    // state | meaning
    // IDLE  | waiting for start_i
    // DZERO | divisor was zero, result forced next cycle
    // CALC  | one restoring step per cycle, WIDTH steps
    // DONE  | result_o valid, ready_o pulses
    typedef enum logic [1:0] {S_IDLE, S_DZERO, S_CALC, S_DONE} state_t;

    localparam int CW = $clog2(WIDTH);

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem, quo, dvs;
    logic             neg_q, neg_r;

    logic             start_ok, dzero_in, last_step, ge;
    logic [WIDTH-1:0] a_mag, b_mag, diff, rem_step, quo_step, q_fix, r_fix;
    logic [WIDTH:0]   rem_sh;

    assign start_ok  = start_i && !annul_i;
    assign dzero_in  = (opdata2_i == '0);
    assign last_step = (cnt == CW'(WIDTH-1));

    // Most-negative operand maps to 2^(WIDTH-1), which is correct when read as unsigned.
    assign a_mag = (signed_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    assign b_mag = (signed_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

    assign rem_sh   = {rem, quo[WIDTH-1]};
    assign ge       = (rem_sh >= {1'b0, dvs});
    assign diff     = rem_sh[WIDTH-1:0] - dvs;
    assign rem_step = ge ? diff : rem_sh[WIDTH-1:0];
    assign quo_step = {quo[WIDTH-2:0], ge};
    assign q_fix    = neg_q ? -quo_step : quo_step;
    assign r_fix    = neg_r ? -rem_step : rem_step;

    always_ff @(posedge clk) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start_ok) state_nxt = dzero_in ? S_DZERO : S_CALC;
            S_DZERO: state_nxt = annul_i ? S_IDLE : S_DONE;
            S_CALC: begin
                if (annul_i)        state_nxt = S_IDLE;
                else if (last_step) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // The final result is registered on the edge entering DONE so it is valid alongside ready_o.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt           <= '0;
            rem           <= '0;
            quo           <= '0;
            dvs           <= '0;
            neg_q         <= 1'b0;
            neg_r         <= 1'b0;
            result_o      <= '0;
            div_by_zero_o <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        neg_q <= signed_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                        neg_r <= signed_i && opdata1_i[WIDTH-1];
                        dvs   <= b_mag;
                        quo   <= dzero_in ? opdata1_i : a_mag;
                        rem   <= '0;
                        cnt   <= '0;
                    end
                end
                S_DZERO: begin
                    if (!annul_i) begin
                        result_o      <= {quo, {WIDTH{1'b1}}};
                        div_by_zero_o <= 1'b1;
                    end
                end
                S_CALC: begin
                    if (!annul_i) begin
                        rem <= rem_step;
                        quo <= quo_step;
                        cnt <= cnt + 1'b1;
                        if (last_step) begin
                            result_o      <= {r_fix, q_fix};
                            div_by_zero_o <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o  = (state != S_IDLE);
    assign ready_o = (state == S_DONE);

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter at WIDTH=32 and WIDTH=8 against an arithmetic reference model.
module tb_div_iter;

    logic        clk = 1'b0;
    logic        rstn32, st32, sg32, an32, busy32, rdy32, dz32;
    logic [31:0] a32, b32;
    logic [63:0] res32;
    logic        rstn8, st8, sg8, an8, busy8, rdy8, dz8;
    logic [7:0]  a8, b8;
    logic [15:0] res8;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    div_iter #(.WIDTH(32)) dut32 (
        .clk(clk), .resetn(rstn32), .start_i(st32), .signed_i(sg32), .annul_i(an32),
        .opdata1_i(a32), .opdata2_i(b32), .busy_o(busy32), .ready_o(rdy32),
        .result_o(res32), .div_by_zero_o(dz32)
    );

    div_iter #(.WIDTH(8)) dut8 (
        .clk(clk), .resetn(rstn8), .start_i(st8), .signed_i(sg8), .annul_i(an8),
        .opdata1_i(a8), .opdata2_i(b8), .busy_o(busy8), .ready_o(rdy8),
        .result_o(res8), .div_by_zero_o(dz8)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: two's-complement divide truncating toward zero, done in 64-bit arithmetic.
    function automatic void ref_div(input logic [63:0] a, input logic [63:0] b, input bit sgn,
                                    input int w, output logic [63:0] q, output logic [63:0] r);
        logic [63:0] mask, ta, tb;
        longint sa, sb, qq, rr;
        mask = (64'd1 << w) - 64'd1;
        if ((b & mask) == 64'd0) begin
            q = mask;
            r = a & mask;
        end else if (sgn) begin
            ta = a << (64 - w);
            tb = b << (64 - w);
            sa = $signed(ta) >>> (64 - w);
            sb = $signed(tb) >>> (64 - w);
            qq = sa / sb;
            rr = sa % sb;
            q  = qq & mask;
            r  = rr & mask;
        end else begin
            sa = longint'(a & mask);
            sb = longint'(b & mask);
            qq = sa / sb;
            rr = sa % sb;
            q  = qq & mask;
            r  = rr & mask;
        end
    endfunction

    task automatic drive(input int w, input logic st, input logic sg,
                         input logic [63:0] a, input logic [63:0] b);
        if (w == 8) begin
            st8 = st; sg8 = sg; a8 = a[7:0]; b8 = b[7:0];
        end else begin
            st32 = st; sg32 = sg; a32 = a[31:0]; b32 = b[31:0];
        end
    endtask

    // Issues one divide at "cycle 0" and follows it to the ready_o cycle.
    task automatic run(input int w, input logic [63:0] a, input logic [63:0] b,
                       input bit sgn, input bit inj, input string tag);
        logic [63:0] eq, er, exp_res, got_res, mask;
        int          lat, exp_lat;
        bit          busy_bad;
        logic        got_dz, o_busy, o_rdy;
        ref_div(a, b, sgn, w, eq, er);
        mask    = (64'd1 << w) - 64'd1;
        exp_res = (w == 8) ? {48'd0, er[7:0], eq[7:0]} : {er[31:0], eq[31:0]};
        exp_lat = ((b & mask) == 64'd0) ? 2 : w + 1;
        lat = 0; busy_bad = 0; got_res = '0; got_dz = 1'b0;
        drive(w, 1'b1, sgn, a, b);
        tick();
        drive(w, 1'b0, 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
        for (int c = 1; c <= w + 8; c++) begin
            o_busy = (w == 8) ? busy8 : busy32;
            o_rdy  = (w == 8) ? rdy8 : rdy32;
            if (!o_busy) busy_bad = 1;
            if (o_rdy) begin
                lat     = c;
                got_res = (w == 8) ? {48'd0, res8} : res32;
                got_dz  = (w == 8) ? dz8 : dz32;
                break;
            end
            if (w == 8) st8 = (inj && c == 4);
            else        st32 = (inj && c == 4);
            tick();
        end
        tick();
        o_busy = (w == 8) ? busy8 : busy32;
        o_rdy  = (w == 8) ? rdy8 : rdy32;
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_res"}, got_res, exp_res);
        chk({tag, "_dz"}, {63'd0, got_dz}, {63'd0, ((b & mask) == 64'd0)});
        chk({tag, "_busy"}, {63'd0, busy_bad}, 64'd0);
        chk({tag, "_after"}, {62'd0, o_busy, o_rdy}, 64'd0);
    endtask

    initial begin
        logic [63:0] hold, ra, rb;
        int          nrdy, mode;
        rstn32 = 1'b0; rstn8 = 1'b0;
        st32 = 0; sg32 = 0; an32 = 0; a32 = '0; b32 = '0;
        st8 = 0; sg8 = 0; an8 = 0; a8 = '0; b8 = '0;
        tick(); tick();
        chk("reset32", {busy32, rdy32, dz32, res32}, 67'd0);
        chk("reset8", {45'd0, busy8, rdy8, dz8, res8}, 64'd0);
        rstn32 = 1'b1; rstn8 = 1'b1;
        tick();

        run(32, 64'd100, 64'd7, 0, 0, "u100_7");
        chk("u100_7_const", res32, 64'h00000002_0000000E);
        run(32, 64'hFFFFFFF9, 64'd2, 1, 0, "sm7_2");
        chk("sm7_2_const", res32, 64'hFFFFFFFF_FFFFFFFD);
        run(32, 64'd7, 64'hFFFFFFFE, 1, 0, "s7_m2");
        chk("s7_m2_const", res32, 64'h00000001_FFFFFFFD);
        run(32, 64'h80000000, 64'hFFFFFFFF, 1, 0, "s_ovf");
        chk("s_ovf_const", res32, 64'h00000000_80000000);
        run(32, 64'hFFFFFFFF, 64'd1, 0, 0, "u_max_1");
        run(32, 64'd5, 64'd0, 0, 0, "u5_0");
        chk("u5_0_const", res32, 64'h00000005_FFFFFFFF);
        run(32, 64'hFFFFFFFB, 64'd0, 1, 0, "sm5_0");
        chk("sm5_0_rem", {32'd0, res32[63:32]}, 64'hFFFFFFFB);

        // start together with annul in IDLE must be dropped
        drive(32, 1'b1, 1'b0, 64'd50, 64'd5);
        an32 = 1'b1;
        tick();
        st32 = 1'b0; an32 = 1'b0;
        chk("start_annul_idle", {63'd0, busy32}, 64'd0);

        // annul mid-CALC at cycle 10, then restart at cycle 11
        hold = res32;
        nrdy = 0;
        drive(32, 1'b1, 1'b0, 64'd1000, 64'd3);
        tick();
        st32 = 1'b0;
        for (int c = 1; c < 10; c++) begin
            if (rdy32) nrdy++;
            tick();
        end
        an32 = 1'b1;
        tick();
        an32 = 1'b0;
        if (rdy32) nrdy++;
        chk("annul_busy", {63'd0, busy32}, 64'd0);
        chk("annul_hold", res32, hold);
        chk("annul_nordy", 64'(nrdy), 64'd0);
        run(32, 64'd9, 64'd3, 0, 0, "after_annul");

        // annul while in DZERO
        hold = res32;
        drive(32, 1'b1, 1'b0, 64'd77, 64'd0);
        tick();
        st32 = 1'b0; an32 = 1'b1;
        tick();
        an32 = 1'b0;
        chk("dz_annul", {res32[62:0] ^ hold[62:0], busy32 | rdy32}, 64'd0);
        tick();

        for (int i = 0; i < 25; i++) begin
            ra = {32'd0, $urandom};
            mode = $urandom_range(0, 4);
            if (mode == 0)      rb = 64'd0;
            else if (mode == 1) rb = {32'd0, 32'($urandom_range(1, 9))};
            else if (mode == 2) rb = {32'd0, -32'($urandom_range(1, 9))};
            else                rb = {32'd0, $urandom};
            if (i % 7 == 3) ra = 64'h80000000;
            run(32, ra, rb, 1'($urandom), 0, $sformatf("rnd32_%0d", i));
        end

        run(8, 64'd200, 64'd13, 0, 1, "w8_200_13");
        chk("w8_200_13_const", {48'd0, res8}, 64'h050F);

        // synchronous reset in the middle of a W=8 divide
        drive(8, 1'b1, 1'b0, 64'd100, 64'd3);
        tick();
        st8 = 1'b0;
        for (int c = 1; c < 4; c++) tick();
        rstn8 = 1'b0;
        tick();
        rstn8 = 1'b1;
        chk("w8_midreset", {45'd0, busy8, rdy8, dz8, res8}, 64'd0);
        nrdy = 0;
        for (int c = 0; c < 15; c++) begin
            if (rdy8 || busy8) nrdy++;
            tick();
        end
        chk("w8_midreset_quiet", 64'(nrdy), 64'd0);

        for (int i = 0; i < 40; i++) begin
            ra = {56'd0, 8'($urandom)};
            rb = (i % 6 == 0) ? 64'd0 : {56'd0, 8'($urandom)};
            if (i % 9 == 4) begin ra = 64'h80; rb = 64'hFF; end
            run(8, ra, rb, 1'($urandom), 1'($urandom), $sformatf("rnd8_%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_iter.md
# div_iter

Parametrised iterative radix-2 integer divider for the EX stage, replacing the fixed 32-bit divider. It accepts one signed or unsigned divide per start pulse and returns quotient and remainder after WIDTH+1 cycles. It also supports early completion on divide-by-zero, mid-operation cancellation, and a busy flag. EX drives it and holds its stall request while `busy_o` is high; `result_o` feeds the HI/LO write path.

## Interface
- WIDTH, 32, operand width in bits; legal range 4..64.
- clk  in  1  rising-edge clock.
- resetn  in  1  synchronous, active-low reset.
- start_i  in  1  request a divide; sampled only in IDLE.
- signed_i  in  1  1 = two's-complement divide, 0 = unsigned; latched with start.
- annul_i  in  1  cancel the operation in progress.
- opdata1_i  in  WIDTH  dividend; latched with start.
- opdata2_i  in  WIDTH  divisor; latched with start.
- busy_o  out  1  high in CALC, DZERO and DONE.
- ready_o  out  1  one-cycle pulse: result_o is valid and newly updated.
- result_o  out  2*WIDTH  {remainder, quotient}; remainder in the upper half (HI), quotient in the lower half (LO).
- div_by_zero_o  out  1  valid with ready_o; high when the divisor was 0.

## Operation
- States: IDLE, DZERO, CALC, DONE.
- IDLE, start_i=1, annul_i=0:
  - Latch signed_i and both operands.
  - Divisor 0: go to DZERO.
  - Otherwise: go to CALC, load the magnitudes and clear counter and partial remainder.
- IDLE, start_i=1 and annul_i=1: annul wins; stay in IDLE.
- Signed mode uses |a| and |b| computed on WIDTH bits, with the most-negative value treated as unsigned 2^(WIDTH-1).
- CALC, one restoring step per cycle:
  - Shift {rem, dividend} left by 1.
  - Trial subtract the divisor on WIDTH+1 bits.
  - Non-negative: keep the difference and set the quotient LSB to 1; otherwise set the quotient LSB to 0.
  - After WIDTH steps (counter = WIDTH-1), go to DONE.
- DONE, sign fix:
  - Quotient is negated when signed and the operand signs differ.
  - Remainder is negated when signed and the dividend is negative.
  - Register result_o, pulse ready_o, return to IDLE.
- Overflow: signed -2^(WIDTH-1) / -1 gives quotient 2^(WIDTH-1) (wraps to the most-negative value) and remainder 0. No flag.
- DZERO: in one cycle go to DONE with quotient = all ones, remainder = dividend (unmodified, any mode), div_by_zero_o=1.
- annul_i=1 in CALC or DZERO: return to IDLE next cycle. No ready_o; result_o and div_by_zero_o keep their old values.
- annul_i in DONE: ignored; the result is delivered.
- start_i outside IDLE: ignored. Operand inputs may change freely after the start cycle.
- result_o holds its last value until the next DONE.

## Timing
- Reset (resetn=0 at a clock edge): state IDLE, busy_o=0, ready_o=0, result_o=0, div_by_zero_o=0, counter and datapath registers 0. This applies from any state, including mid-CALC; the aborted operation produces no ready_o.
- Start sampled at edge E0. busy_o is high from E0 until the edge after the DONE cycle.
- Normal latency: CALC occupies cycles 1..WIDTH, DONE is cycle WIDTH+1. ready_o=1 for exactly that cycle, with result_o valid in the same cycle. For WIDTH=32 this is cycle 33.
- Divide-by-zero latency: DZERO is cycle 1, DONE is cycle 2.
- Back-to-back: start_i may be asserted in the cycle after DONE (IDLE). Minimum issue interval is WIDTH+2 cycles.
- EX stall rule: stall while (start condition met in IDLE) or (busy_o=1 and ready_o=0). Release in the ready_o cycle.
- All outputs are registered or decoded from registered state; there is no combinational input-to-output path.

## Test plan
- WIDTH=32, unsigned 100/7, start at cycle 0 -> busy_o cycles 1..33; ready_o only at cycle 33; result_o=0x00000002_0000000E, div_by_zero_o=0.
- WIDTH=32, signed -7/2 (0xFFFFFFF9/0x00000002) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Also 7/-2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
- WIDTH=32, signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0, ready_o at cycle 33. Unsigned 0xFFFFFFFF / 1 -> quotient 0xFFFFFFFF, remainder 0.
- Unsigned 5/0 -> ready_o at cycle 2, quotient 0xFFFFFFFF, remainder 5, div_by_zero_o=1. Signed -5/0 -> remainder 0xFFFFFFFB.
- Divide started, annul_i pulsed at cycle 10 -> busy_o=0 at cycle 11, no ready_o, result_o unchanged. A new start at cycle 11 (9/3) -> ready_o at cycle 44, result 0x0_3.
- WIDTH=8: unsigned 200/13 -> ready_o at cycle 9, result_o=0x050F. In a second divide, resetn=0 at cycle 4 -> all outputs 0 the next cycle, no ready_o. A start_i pulse during CALC is ignored.
